// File: rtl/inst_fetch.sv
// inst_fetch: single-outstanding instruction fetch with a one-entry skid buffer,
// redirect draining and a registered one-hot opcode predecode.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic [31:0] inst_enable,
  output logic        valid
);
  localparam logic [1:0] FETCH = 2'd0, SKID = 2'd1, DRAIN = 2'd2;
  logic [1:0]  state;
  logic [31:0] fetch_pc, drain_pc, skid_pc, skid_inst;
  logic        done, free;
  function automatic logic [31:0] predecode(input logic [31:0] w);
    return (w[1:0] == 2'b11) ? ~(32'h1 << w[6:2]) : '1;
  endfunction
  // Request is gated by reset so no transfer starts while rst is low.
  assign imem_req  = !(rst && state != SKID);
  assign imem_addr = (state == DRAIN) ? drain_pc : fetch_pc;
  assign done      = !imem_req && !imem_ready;
  assign free      = valid || stall;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state       <= FETCH;
      fetch_pc    <= RESET_PC;
      drain_pc    <= '0;
      skid_pc     <= '0;
      skid_inst   <= '0;
      pc          <= '0;
      inst        <= '0;
      inst_enable <= '1;
      valid       <= 1'b1;
    end else if (!redirect) begin
      valid       <= 1'b1;
      inst_enable <= '1;
      fetch_pc    <= {redirect_pc[31:2], 2'b00};
      state       <= (state != SKID && imem_ready) ? DRAIN : FETCH;
      if (state == FETCH) drain_pc <= fetch_pc;
    end else begin
      if (free) begin
        valid       <= 1'b1;
        inst_enable <= '1;
      end
      case (state)
        FETCH: if (done) begin
          fetch_pc <= fetch_pc + 32'd4;
          if (free) begin
            pc          <= fetch_pc;
            inst        <= imem_rdata;
            inst_enable <= predecode(imem_rdata);
            valid       <= 1'b0;
          end else begin
            skid_pc   <= fetch_pc;
            skid_inst <= imem_rdata;
            state     <= SKID;
          end
        end
        SKID: if (free) begin
          pc          <= skid_pc;
          inst        <= skid_inst;
          inst_enable <= predecode(skid_inst);
          valid       <= 1'b0;
          state       <= FETCH;
        end
        default: if (done) state <= FETCH;
      endcase
    end
endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h0000_0000, which is the first fetch address after reset.
REQ-002 The module SHALL have input clk, 1 bit: the system clock. All state changes on the rising edge.
REQ-003 The module SHALL have input rst, 1 bit: reset, asynchronous, ACTIVE LOW.
REQ-004 The module SHALL have output imem_req, 1 bit: instruction memory request, ACTIVE LOW.
REQ-005 The module SHALL have output imem_addr, 32 bits: fetch address, word aligned.
REQ-006 The module SHALL have input imem_rdata, 32 bits: the fetched word, valid while imem_ready is low.
REQ-007 The module SHALL have input imem_ready, 1 bit: the transfer completes on an edge where imem_ready and imem_req are both low. ACTIVE LOW.
REQ-008 The module SHALL have input redirect, 1 bit: branch/jump/trap redirect, ACTIVE LOW.
REQ-009 The module SHALL have input redirect_pc, 32 bits: the redirect target; bits [1:0] are ignored and treated as 00.
REQ-010 The module SHALL have input stall, 1 bit: downstream hold, ACTIVE LOW. Low means the decode stage does not accept the output register.
REQ-011 The module SHALL have output pc, 32 bits: the address of the instruction held in the output register.
REQ-012 The module SHALL have output inst, 32 bits: the held instruction.
REQ-013 The module SHALL have output inst_enable, 32 bits: one-hot opcode predecode, ACTIVE LOW.
REQ-014 The module SHALL have output valid, 1 bit: the output register holds an instruction, ACTIVE LOW.

Function
REQ-015 The module SHALL have states FETCH, SKID and DRAIN, plus an output register (pc/inst/inst_enable/valid), a skid buffer (pc and word) and fetch_pc.
REQ-016 In FETCH the module SHALL drive imem_req low and imem_addr = fetch_pc; in SKID and DRAIN (DRAIN: see REQ-023) it SHALL hold imem_req and imem_addr as stated per state.
REQ-017 Once imem_req is low, imem_req and imem_addr SHALL stay stable until the completing edge; a redirect or stall does not withdraw a request.
REQ-018 The output register is free on an edge when valid is high, or when valid is low and stall is high (consumed).
REQ-019 On a FETCH completion with the output register free, the module SHALL load the output register with {fetch_pc, imem_rdata} and drive valid low; fetch_pc += 4; the state stays FETCH.
REQ-020 On a FETCH completion with the output register not free, the module SHALL store the word in the skid buffer, set fetch_pc += 4 and go to SKID.
- SKID: imem_req is high.
- When the output register is free, the skid buffer moves to the output register (valid low) and the state returns to FETCH.
REQ-021 A consumed output register with no new load on the same edge SHALL set valid high.
REQ-022 fetch_pc arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-023 A redirect low on an edge SHALL take priority over stall and over any load. On that edge:
- valid goes high.
- The skid buffer is discarded.
- fetch_pc is set to {redirect_pc[31:2], 2'b00}.
- If the state was FETCH and imem_ready was high (transfer outstanding), the state goes to DRAIN.
- Otherwise the state goes to FETCH.
REQ-024 In DRAIN the module SHALL keep imem_req low with the old address. On completion it SHALL discard the data and go to FETCH at the redirected fetch_pc. A further redirect in DRAIN only updates fetch_pc.
REQ-025 A FETCH completion on the same edge as a redirect SHALL be discarded, and the next state SHALL be FETCH.
REQ-026 The inst_enable bit k SHALL be low only when valid is low, inst[1:0]==2'b11 and inst[6:2]==k. Otherwise all 32 bits are high.
REQ-027 The module SHALL register inst_enable together with inst; it SHALL NOT be decoded from imem_rdata combinationally at the output.
REQ-028 The latency from completion to valid low SHALL be 1 edge. With zero-wait memory (imem_ready tied low) and stall high, the module SHALL deliver one instruction per cycle.

Reset
REQ-029 While rst is low, the module SHALL set:
- state = FETCH, fetch_pc = RESET_PC.
- pc = 0, inst = 0.
- inst_enable = 32'hFFFF_FFFF, valid = 1.
- Skid buffer cleared.
REQ-030 While rst is low, imem_req SHALL be high. It SHALL go low in the first cycle after rst rises.
REQ-031 A reset in SKID or DRAIN SHALL abandon the buffered or outstanding transfer without any further imem_req until rst is high.

Verification
REQ-032 Reset release, RESET_PC=0, imem_ready tied low, memory returning 32'h00000013 -> imem_addr 0,4,8 on consecutive cycles; valid low from the 2nd edge; pc 0,4,8; inst_enable = ~(32'h1<<4).
REQ-033 Hold stall low for 3 cycles in a zero-wait stream -> pc/inst frozen, exactly one word in skid, imem_req high while in SKID; after release the stream resumes with no gap, no loss and no duplicate.
REQ-034 Memory with 2 wait states, redirect low to 32'h0000_0103 mid-transfer -> old address held until ready; data discarded; next imem_addr = 32'h0000_0100; valid high throughout.
REQ-035 Redirect on the same edge as completion and stall low -> valid high next cycle; skid empty; next fetch at the redirect target.
REQ-036 fetch_pc = 32'hFFFF_FFFC -> next imem_addr 32'h0000_0000.
REQ-037 rst low while in SKID -> all outputs at reset values; after release the first imem_addr is RESET_PC.
REQ-038 inst = 32'h12345677 (bits [1:0]=11, opcode 5'b11101) -> inst_enable = ~(32'h1<<29); inst = 32'h00000001 -> inst_enable = 32'hFFFF_FFFF.
